// File: rtl/sha_port_arbiter_if.sv
// Signal bundle between the SHA port arbiter, its requesters and the shared
// SHA-256 core command/data port. The arbiter uses the slave view; whatever
// drives the requesters and models the core uses the master view.
interface sha_port_arbiter_if #(
    parameter int NUM_REQ = 2
);
    // Requester side: one lane per requester, packed side by side.
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    gnt;
    logic [3*NUM_REQ-1:0]  req_cmd;
    logic [NUM_REQ-1:0]    req_cmd_w;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_done;
    logic [3:0]            status_o;

    // Core side: the single shared command/data port.
    logic [2:0]            sha_cmd;
    logic                  sha_cmd_w;
    logic [31:0]           sha_data;
    logic [3:0]            sha_status;
    logic                  sha_done;

    // Watchdog reporting.
    logic                  timeout_err;
    logic [1:0]            err_id;

    modport slave (
        input  req,
        input  req_cmd,
        input  req_cmd_w,
        input  req_data,
        input  sha_status,
        input  sha_done,
        output gnt,
        output req_done,
        output status_o,
        output sha_cmd,
        output sha_cmd_w,
        output sha_data,
        output timeout_err,
        output err_id
    );

    modport master (
        output req,
        output req_cmd,
        output req_cmd_w,
        output req_data,
        output sha_status,
        output sha_done,
        input  gnt,
        input  req_done,
        input  status_o,
        input  sha_cmd,
        input  sha_cmd_w,
        input  sha_data,
        input  timeout_err,
        input  err_id
    );
endinterface

// File: rtl/sha_port_arbiter.sv
// Round-robin arbiter sharing one SHA-256 core command/data port between
// NUM_REQ requesters (2..4). The owner's cmd/cmd_w/data bundle is registered
// onto the core with one cycle of latency, the core's done is routed back to
// the owner only, and a grant held for MAX_HOLD cycles is forcibly revoked
// and the offender locked out until it drops its request.
// Parameter constraints: 2 <= NUM_REQ <= 4, MAX_HOLD >= 2, 2**HW > MAX_HOLD.
module sha_port_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int MAX_HOLD = 4096,
    parameter int HW       = 13
) (
    input logic               clk,
    input logic               rst,
    sha_port_arbiter_if.slave bus
);

    localparam int              PW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [HW-1:0]   HOLD_LIMIT = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [NUM_REQ-1:0]   lockout_q, lockout_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [2:0]           cmd_q, cmd_d;
    logic                 cmd_w_q, cmd_w_d;
    logic [31:0]          data_q, data_d;
    logic                 terr_q, terr_d;
    logic [1:0]           err_id_q, err_id_d;

    // Per-requester views of the packed request buses.
    logic [2:0]           cmd_arr   [NUM_REQ];
    logic [31:0]          data_arr  [NUM_REQ];
    logic                 cmd_w_arr [NUM_REQ];

    logic [NUM_REQ-1:0]   eligible;
    logic                 pick_valid;
    logic [PW-1:0]        pick_idx;
    logic [PW-1:0]        cand;
    logic [PW-1:0]        next_ptr;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign cmd_arr[g]   = bus.req_cmd[3*g +: 3];
        assign data_arr[g]  = bus.req_data[32*g +: 32];
        assign cmd_w_arr[g] = bus.req_cmd_w[g];
    end

    // A locked-out requester stays ineligible until it lowers req.
    assign eligible = bus.req & ~lockout_q;

    // After a grant ends, the search starts just past the outgoing owner.
    assign next_ptr = PW'((int'(owner_q) + 1) % NUM_REQ);

    // Round-robin pick: first eligible index at or after ptr, with wrap.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        // Walking from the farthest offset down lets the nearest hit win
        // without an early loop exit.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr_q) + k) % NUM_REQ);
            if (eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and next-output decode for the grant FSM.
    always_comb begin
        // NOTE: every variable gets a default before the case so that no
        // path leaves it unassigned; a missing default infers a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        lockout_d = lockout_q & bus.req;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        done_d    = done_q;
        cmd_d     = cmd_q;
        cmd_w_d   = 1'b0;
        data_d    = data_q;
        terr_d    = 1'b0;
        err_id_d  = err_id_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    owner_d         = pick_idx;
                    hold_d          = '0;
                    state_d         = GRANT;
                end
            end

            GRANT: begin
                cmd_d           = cmd_arr[owner_q];
                data_d          = data_arr[owner_q];
                cmd_w_d         = cmd_w_arr[owner_q];
                done_d          = '0;
                done_d[owner_q] = bus.sha_done;
                hold_d          = hold_q + HW'(1);

                // A voluntary drop wins over the watchdog on the same edge.
                if (!bus.req[owner_q]) begin
                    gnt_d   = '0;
                    ptr_d   = next_ptr;
                    state_d = RELEASE;
                end else if (hold_q == HOLD_LIMIT) begin
                    gnt_d              = '0;
                    terr_d             = 1'b1;
                    err_id_d           = 2'(owner_q);
                    lockout_d[owner_q] = 1'b1;
                    ptr_d              = next_ptr;
                    state_d            = RELEASE;
                end
            end

            RELEASE: begin
                cmd_d   = '0;
                data_d  = '0;
                done_d  = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration bookkeeping and registered core/requester outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            owner_q   <= '0;
            lockout_q <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            cmd_q     <= '0;
            cmd_w_q   <= 1'b0;
            data_q    <= '0;
            terr_q    <= 1'b0;
            err_id_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            lockout_q <= lockout_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            cmd_q     <= cmd_d;
            cmd_w_q   <= cmd_w_d;
            data_q    <= data_d;
            terr_q    <= terr_d;
            err_id_q  <= err_id_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.req_done    = done_q;
    assign bus.sha_cmd     = cmd_q;
    assign bus.sha_cmd_w   = cmd_w_q;
    assign bus.sha_data    = data_q;
    assign bus.timeout_err = terr_q;
    assign bus.err_id      = err_id_q;

    // Status passes straight through; only the owner may interpret it.
    assign bus.status_o    = bus.sha_status;

endmodule
